// File: rtl/sign_max_pkg.sv
// Shared types and constants for the streaming signed-maximum finder.
// The FSM state encoding lives here so any companion logic can decode it.
package sign_max_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LEN_W = 8;

  localparam logic [DEFAULT_WIDTH-1:0] SMIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    ACCEPT = 3'd2,
    CMP    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/XYF.sv
// Signed comparator: AGEB is high when DataA >= DataB (two's complement).
// Purely combinational; the max finder registers both operands.
module XYF #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  output logic             AGEB
);

  assign AGEB = ($signed(DataA) >= $signed(DataB));

endmodule

// File: rtl/sign_max_seq.sv
// Streaming signed-maximum finder. Drives an external comparator with the
// candidate sample (DataA) and the running maximum (DataB), and reads AGEB back.
module sign_max_seq
  import sign_max_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEN_W = DEFAULT_LEN_W
) (
  input  logic             SYSCLK,
  input  logic             NSYSRESET,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] DataA,
  output logic [WIDTH-1:0] DataB,
  input  logic             AGEB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_val,
  output logic [LEN_W-1:0] max_idx
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] best_idx_q, best_idx_d;
  logic [LEN_W-1:0] max_idx_q, max_idx_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [WIDTH-1:0] data_a_q, data_a_d;
  logic [WIDTH-1:0] data_b_q, data_b_d;
  logic [WIDTH-1:0] max_val_q, max_val_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             xfer;
  logic [LEN_W-1:0] cnt_inc;

  assign xfer    = s_valid && s_ready_q;
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    max_val_d  = max_val_q;
    max_idx_d  = max_idx_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len == '0) begin
            // Empty frame reports the most negative value at index 0.
            best_d     = MIN_VAL;
            best_idx_d = '0;
            state_d    = DONE;
          end else begin
            len_d   = frame_len;
            state_d = FIRST;
          end
        end
      end
      FIRST: begin
        if (xfer) begin
          best_d     = s_data;
          best_idx_d = '0;
          data_b_d   = s_data;
          cnt_d      = ONE;
          state_d    = (len_q == ONE) ? DONE : ACCEPT;
        end
      end
      ACCEPT: begin
        if (xfer) begin
          data_a_d = s_data;
          state_d  = CMP;
        end
      end
      CMP: begin
        // Ties take the newer sample, so the latest equal value wins.
        if (AGEB) begin
          best_d     = data_a_q;
          data_b_d   = data_a_q;
          best_idx_d = cnt_q;
        end
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? DONE : ACCEPT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == DONE) && (state_q != DONE)) begin
      max_val_d = best_d;
      max_idx_d = best_idx_d;
    end

    // Moore outputs are registered from the next state so they line up with it.
    s_ready_d = (state_d == FIRST) || (state_d == ACCEPT);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      max_val_q  <= '0;
      max_idx_q  <= '0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      max_val_q  <= max_val_d;
      max_idx_q  <= max_idx_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign s_ready = s_ready_q;
  assign DataA   = data_a_q;
  assign DataB   = data_b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

endmodule

// File: tb/tb_sign_max_seq.sv
// Bench for sign_max_seq wired to an XYF comparator: table-driven frames
// plus a hand-written abort/restart sequence.
module tb_sign_max_seq;

  localparam int W  = 8;
  localparam int LW = 8;
  localparam int NV = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, AGEB, busy, done;
  logic [W-1:0]  DataA, DataB, max_val;
  logic [LW-1:0] max_idx;

  int checks = 0;
  int errors = 0;
  int done_count = 0;

  typedef struct {
    int           len;
    logic [W-1:0] d [0:4];
    int           gap;
    logic [W-1:0] exp_max;
    logic [LW-1:0] exp_idx;
    int           exp_lat;
  } vec_t;

  vec_t vecs [0:NV-1];

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_count <= done_count + 1;

  sign_max_seq #(.WIDTH(W), .LEN_W(LW)) dut (
    .SYSCLK(clk), .NSYSRESET(rst_n), .start(start), .frame_len(frame_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .DataA(DataA), .DataB(DataB), .AGEB(AGEB),
    .busy(busy), .done(done), .max_val(max_val), .max_idx(max_idx)
  );

  XYF #(.WIDTH(W)) u_xyf (.DataA(DataA), .DataB(DataB), .AGEB(AGEB));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that took start.
  task automatic do_start(input int len);
    start     = 1'b1;
    frame_len = LW'(len);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called off-edge; returns 1 time unit after the edge that accepted the sample.
  task automatic send(input logic [W-1:0] d);
    int b;
    b       = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && b < 20) begin
      @(negedge clk);
      b++;
    end
    if (b >= 20) chk("s_ready timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat,
                           input logic [W-1:0] em, input logic [LW-1:0] ei);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " max_val"}, 32'(max_val), 32'(em));
    chk({nm, " max_idx"}, 32'(max_idx), 32'(ei));
    @(negedge clk);
    chk({nm, " done width"}, 32'(done), 32'd0);
    chk({nm, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int done_before;

    vecs[0].len = 4; vecs[0].d = '{8'h03, 8'hFB, 8'h7F, 8'h80, 8'h00};
    vecs[0].gap = 0; vecs[0].exp_max = 8'h7F; vecs[0].exp_idx = 8'd2; vecs[0].exp_lat = 2;
    vecs[1].len = 3; vecs[1].d = '{8'hFF, 8'hF9, 8'h80, 8'h00, 8'h00};
    vecs[1].gap = 0; vecs[1].exp_max = 8'hFF; vecs[1].exp_idx = 8'd0; vecs[1].exp_lat = 2;
    vecs[2].len = 3; vecs[2].d = '{8'h05, 8'h05, 8'h02, 8'h00, 8'h00};
    vecs[2].gap = 0; vecs[2].exp_max = 8'h05; vecs[2].exp_idx = 8'd1; vecs[2].exp_lat = 2;
    vecs[3].len = 0; vecs[3].d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].gap = 0; vecs[3].exp_max = 8'h80; vecs[3].exp_idx = 8'd0; vecs[3].exp_lat = 1;
    vecs[4].len = 1; vecs[4].d = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4].gap = 3; vecs[4].exp_max = 8'h80; vecs[4].exp_idx = 8'd0; vecs[4].exp_lat = 1;
    vecs[5].len = 5; vecs[5].d = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    vecs[5].gap = 0; vecs[5].exp_max = 8'h80; vecs[5].exp_idx = 8'd4; vecs[5].exp_lat = 2;

    // Reset state
    #12;
    chk("reset s_ready", 32'(s_ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset DataB", 32'(DataB), 32'd0);
    chk("reset max_val", 32'(max_val), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) begin
      do_start(vecs[v].len);
      if (vecs[v].len == 0) begin
        chk("len0 s_ready", 32'(s_ready), 32'd0);
      end else begin
        chk("frame busy", 32'(busy), 32'd1);
        for (int g = 0; g < vecs[v].gap; g++) begin
          @(negedge clk);
          chk("first s_ready hold", 32'(s_ready), 32'd1);
        end
        for (int i = 0; i < vecs[v].len; i++) send(vecs[v].d[i]);
      end
      wait_done($sformatf("vec%0d", v), vecs[v].exp_lat, vecs[v].exp_max, vecs[v].exp_idx);
      $display("frame %0d len %0d max_val %0h max_idx %0d", v, vecs[v].len, max_val, max_idx);
      @(posedge clk);
      #1;
    end

    // Abort a frame mid-stream; a start pulse while busy must be ignored.
    done_before = done_count;
    do_start(5);
    send(8'h03);
    send(8'h7F);
    start     = 1'b1;
    frame_len = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start ignored busy", 32'(busy), 32'd1);
    send(8'h01);
    chk("start ignored DataB", 32'(DataB), 32'h7F);
    chk("start ignored DataA", 32'(DataA), 32'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort s_ready", 32'(s_ready), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort DataA", 32'(DataA), 32'd0);
    chk("abort DataB", 32'(DataB), 32'd0);
    chk("abort max_val", 32'(max_val), 32'd0);
    chk("abort max_idx", 32'(max_idx), 32'd0);
    repeat (2) @(negedge clk);
    chk("abort no done", 32'(done_count), 32'(done_before));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(2);
    send(8'h02);
    send(8'h09);
    wait_done("restart", 2, 8'h09, 8'd1);
    $display("frame restart len 2 max_val %0h max_idx %0d", max_val, max_idx);
    repeat (3) @(negedge clk);
    chk("max_val held", 32'(max_val), 32'h09);
    chk("max_idx held", 32'(max_idx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
